// File: rtl/mem_dump_uart.sv
// mem_dump_uart
//   Walks a block of 16-bit words in a synchronous RAM and streams each one
//   over an 8N1 UART as four lowercase hex digits followed by CR LF.
//
// Ports
//   clk         single clock
//   reset       synchronous, active-high reset
//   start       request a dump (ignored while busy)
//   start_addr  first word address, latched when start is accepted
//   word_count  number of words to dump, latched when start is accepted
//   mem_rd      read strobe to the RAM (one cycle per word)
//   mem_addr    read address, held between reads
//   mem_q       RAM read data, valid the cycle after mem_rd
//   txd         UART serial output, idle high
//   busy        high from start acceptance until done
//   done        one-cycle pulse when the dump completes
module mem_dump_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W + 1)'(0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    NEXT    = 3'd4,
    FIN     = 3'd5
  } state_t;

  // ASCII for one nibble: '0'-'9' then 'a'-'f'
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h57 + {4'h0, n};
    end
    return r;
  endfunction

  // Byte idx of the six-byte line for word w: 4 hex digits MS first, CR, LF
  function automatic logic [7:0] dump_byte(input logic [15:0] w, input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = hex_ascii(w[15:12]);
      3'd1:    r = hex_ascii(w[11:8]);
      3'd2:    r = hex_ascii(w[7:4]);
      3'd3:    r = hex_ascii(w[3:0]);
      3'd4:    r = 8'h0D;
      default: r = 8'h0A;
    endcase
    return r;
  endfunction

  // Line level for frame position bit_idx: 0 = start, 1..8 = data LSB first, 9 = stop
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] bit_idx);
    logic       r;
    logic [2:0] sel;
    sel = 3'(bit_idx - 4'd1);
    if (bit_idx == 4'd0) begin
      r = 1'b0;
    end else if (bit_idx <= 4'd8) begin
      r = b[sel];
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [15:0]         shadow_q, shadow_d;
  logic [2:0]          byte_q, byte_d;
  logic [3:0]          bit_q, bit_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  // Next-state, counter and output decode; outputs are computed for the
  // upcoming state so that every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    shadow_d   = shadow_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    baud_d     = baud_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    txd_d      = 1'b1;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = start_addr;
          cnt_d  = word_count;
          busy_d = 1'b1;
          if (word_count == CNT_ZERO) begin
            state_d = FIN;
          end else begin
            state_d = READ;
          end
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      READ: begin
        busy_d  = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        busy_d   = 1'b1;
        shadow_d = mem_q[15:0];
        byte_d   = 3'd0;
        bit_d    = 4'd0;
        baud_d   = {BAUD_W{1'b0}};
        state_d  = SEND;
      end
      SEND: begin
        busy_d = 1'b1;
        if (baud_q == BAUD_MAX) begin
          baud_d = {BAUD_W{1'b0}};
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (byte_q == 3'd5) begin
              state_d = NEXT;
            end else begin
              byte_d = byte_q + 3'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      NEXT: begin
        busy_d = 1'b1;
        addr_d = addr_q + ADDR_ONE;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_d != CNT_ZERO) begin
          state_d = READ;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        // done rises and busy falls together on the edge leaving FIN
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (state_d == READ) begin
      mem_rd_d   = 1'b1;
      mem_addr_d = addr_d;
    end else begin
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
    end

    if (state_d == SEND) begin
      txd_d = frame_bit(dump_byte(shadow_d, byte_d), bit_d);
    end else begin
      txd_d = 1'b1;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      cnt_q      <= CNT_ZERO;
      shadow_q   <= 16'h0000;
      byte_q     <= 3'd0;
      bit_q      <= 4'd0;
      baud_q     <= {BAUD_W{1'b0}};
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= {ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      baud_q     <= baud_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign txd      = txd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule
